swi_reset_sequencer: RTL and testbench
======================================

Name: swi_reset_sequencer

Overview:
Parametrised successor to the 2-flop cpu_resetrequest synchroniser in the boot top level. It synchronises NUM_REQ asynchronous reset-request sources and drives the Nios II cpu_resetrequest/cpu_resettaken handshake with a guaranteed minimum assertion time. If the CPU never acknowledges, it escalates to a timed hard reset pulse. It records the reset cause and keeps a count of resets for the boot loader.

Parameters:
NUM_REQ, 2, number of reset-request sources (1..8)
SYNC_STAGES, 2, synchroniser flops per source (>=2)
MIN_ASSERT, 16, minimum cycles cpu_resetrequest stays high (>=1)
TAKEN_TIMEOUT, 1024, cycles allowed for cpu_resettaken before escalation (>=2)
HARD_PULSE, 32, cycles hard_reset_n is held low on escalation (>=1)

Ports:
clock_core_sig  in  1  core clock; all logic on rising edge
qsys_reset_n_sig  in  1  asynchronous active-low reset
req_in  in  NUM_REQ  asynchronous level reset requests (e.g. swi_cpu_resetrequest)
req_mask  in  NUM_REQ  synchronous; 1 = ignore source
cpu_resettaken  in  1  synchronous ack from Nios II
clear_status  in  1  synchronous; clears timeout_flag
cpu_resetrequest  out  1  to Nios II cpu_resetrequest
hard_reset_n  out  1  active-low hard reset to the mreset domain
busy  out  1  high whenever state != IDLE
last_cause  out  NUM_REQ  unmasked synchronised requests captured at trigger
timeout_flag  out  1  sticky; set on escalation
reset_count  out  8  number of sequences started, saturates at 255

Behaviour:
- Reset: qsys_reset_n_sig, asynchronous, active-low; clock clock_core_sig. While reset is low: all sync flops 0, state IDLE, cpu_resetrequest=0, hard_reset_n=1, busy=0, last_cause=0, timeout_flag=0, reset_count=0, counters 0. A reset during any state aborts the sequence immediately.
- Sync: each req_in bit passes through SYNC_STAGES flops. trigger = |(req_sync & ~req_mask).
- All outputs are registered. busy is decoded from the state register.
- t_cnt: cycles spent with cpu_resetrequest high. Cleared on IDLE->REQ, then increments each cycle and saturates. Width is clog2(max(MIN_ASSERT,TAKEN_TIMEOUT)+1).
- IDLE: cpu_resetrequest=0. If trigger=1, the next state is REQ and cpu_resetrequest=1 in the same edge. last_cause is latched to req_sync & ~req_mask, and reset_count increments if below 255. cpu_resettaken is ignored in IDLE.
- Latency: if E1 is the first edge that samples req_in high, cpu_resetrequest rises at edge E(SYNC_STAGES+1), which is E3 by default.
- REQ: cpu_resetrequest=1.
  - If cpu_resettaken=1, go to HOLD.
  - Otherwise, if t_cnt reaches TAKEN_TIMEOUT, go to HARD: hard_reset_n=0, timeout_flag=1, p_cnt cleared.
  - If taken and the timeout occur in the same cycle, taken wins and the next state is HOLD.
- HARD: cpu_resetrequest=1, hard_reset_n=0. After exactly HARD_PULSE cycles with hard_reset_n low, hard_reset_n returns to 1 and the state goes to HOLD.
- HOLD: cpu_resetrequest=1. When t_cnt >= MIN_ASSERT and trigger=0, go to IDLE and cpu_resetrequest=0 at that edge. Otherwise stay; a held request keeps the CPU in reset indefinitely.
- Masking a source mid-sequence removes it from trigger only; it does not abort REQ or HARD.
- A new trigger arriving in IDLE the cycle after release starts a new sequence with no dead time.
- timeout_flag: cleared by clear_status. If set and clear occur in the same cycle, set wins.
- last_cause and reset_count change only on IDLE->REQ.

Test Plan:
1. Defaults; req_in[0] rises before E1, cpu_resettaken pulses 3 cycles after request. Required: cpu_resetrequest=1 at E3; release after 16 high cycles if req_in drops early; last_cause=2'b01; reset_count=1; timeout_flag=0.
2. req_in[1] held for 100 cycles, cpu_resettaken given. Required: cpu_resetrequest stays high until trigger falls, then drops one cycle later (SYNC_STAGES+1 edges after req_in falls); last_cause=2'b10.
3. Request with cpu_resettaken never asserted. Required: hard_reset_n falls after 1024 high cycles and stays low exactly 32 cycles; timeout_flag=1; busy=1 throughout; then IDLE once the request is low. clear_status in the same cycle as the set leaves timeout_flag=1.
4. req_mask=2'b01 with req_in=2'b01. Required: no sequence starts. Then mask cleared mid-HOLD of a req_in[1] sequence: release is delayed until req_in[0] also drops.
5. 260 back-to-back sequences. Required: reset_count saturates at 255. Assert qsys_reset_n_sig low in REQ and in HARD: all outputs return to reset values asynchronously, with hard_reset_n=1 and cpu_resetrequest=0 within that cycle.
6. cpu_resettaken and the timeout edge in the same cycle. Required: next state HOLD, hard_reset_n stays 1, timeout_flag=0.

Source files
------------

// File: rtl/swi_reset_sequencer.sv
// swi_reset_sequencer: synchronises NUM_REQ asynchronous reset-request sources and runs
// the Nios II cpu_resetrequest/cpu_resettaken handshake with a minimum assertion time.
// If the CPU never acknowledges, it escalates to a timed active-low hard reset pulse.
// Latency: cpu_resetrequest rises SYNC_STAGES+1 edges after req_in is first sampled high.
// Backpressure: none; a request that stays high keeps the CPU in reset indefinitely.
// Ports:
//   clock_core_sig, qsys_reset_n_sig : core clock, async active-low reset
//   req_in, req_mask                 : async request levels, sync per-source ignore mask
//   cpu_resettaken                   : CPU acknowledge (ignored while idle)
//   clear_status                     : clears timeout_flag (a same-cycle set wins)
//   cpu_resetrequest, hard_reset_n   : handshake request to the CPU, hard reset to mreset
//   busy, last_cause, timeout_flag   : sequence active, cause at trigger, sticky escalation
//   reset_count                      : sequences started, saturating at 255
module swi_reset_sequencer #(
  parameter int NUM_REQ       = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int MIN_ASSERT    = 16,
  parameter int TAKEN_TIMEOUT = 1024,
  parameter int HARD_PULSE    = 32
) (
  input  logic               clock_core_sig,
  input  logic               qsys_reset_n_sig,
  input  logic [NUM_REQ-1:0] req_in,
  input  logic [NUM_REQ-1:0] req_mask,
  input  logic               cpu_resettaken,
  input  logic               clear_status,
  output logic               cpu_resetrequest,
  output logic               hard_reset_n,
  output logic               busy,
  output logic [NUM_REQ-1:0] last_cause,
  output logic               timeout_flag,
  output logic [7:0]         reset_count
);

  localparam int T_MAX = (MIN_ASSERT > TAKEN_TIMEOUT) ? MIN_ASSERT : TAKEN_TIMEOUT;
  localparam int TW    = $clog2(T_MAX + 1);
  localparam int PW    = $clog2(HARD_PULSE + 1);

  localparam logic [TW-1:0] T_SAT  = TW'(T_MAX);
  localparam logic [TW-1:0] T_MIN  = TW'(MIN_ASSERT);
  localparam logic [TW-1:0] T_TO   = TW'(TAKEN_TIMEOUT);
  localparam logic [PW-1:0] P_LAST = PW'(HARD_PULSE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HARD = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t                           state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_REQ-1:0] sync_q, sync_d;
  logic [TW-1:0]                    t_cnt_q, t_cnt_d;
  logic [PW-1:0]                    p_cnt_q, p_cnt_d;
  logic                             cpu_resetrequest_q, cpu_resetrequest_d;
  logic                             hard_reset_n_q, hard_reset_n_d;
  logic [NUM_REQ-1:0]               last_cause_q, last_cause_d;
  logic                             timeout_flag_q, timeout_flag_d;
  logic [7:0]                       reset_count_q, reset_count_d;

  logic [NUM_REQ-1:0]               req_live;
  logic                             trigger;
  logic [TW-1:0]                    t_elapsed;

  // Synchroniser chain: stage 0 samples the raw request, the last stage feeds the trigger.
  always_comb begin
    sync_d    = '0;
    sync_d[0] = req_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign req_live = sync_q[SYNC_STAGES-1] & ~req_mask;
  assign trigger  = |req_live;

  // High cycles completed as of the coming edge; thresholds compare against this so that
  // MIN_ASSERT and TAKEN_TIMEOUT are exact counts of cycles with cpu_resetrequest high.
  assign t_elapsed = (t_cnt_q == T_SAT) ? T_SAT : t_cnt_q + 1'b1;

  always_comb begin
    state_d            = state_q;
    t_cnt_d            = t_cnt_q;
    p_cnt_d            = p_cnt_q;
    cpu_resetrequest_d = cpu_resetrequest_q;
    hard_reset_n_d     = hard_reset_n_q;
    last_cause_d       = last_cause_q;
    reset_count_d      = reset_count_q;
    timeout_flag_d     = clear_status ? 1'b0 : timeout_flag_q;

    unique case (state_q)
      ST_IDLE: begin
        cpu_resetrequest_d = 1'b0;
        hard_reset_n_d     = 1'b1;
        if (trigger) begin
          state_d            = ST_REQ;
          cpu_resetrequest_d = 1'b1;
          t_cnt_d            = '0;
          last_cause_d       = req_live;
          if (reset_count_q != 8'hFF) begin
            reset_count_d = reset_count_q + 8'd1;
          end
        end
      end
      ST_REQ: begin
        t_cnt_d = t_elapsed;
        // An acknowledge in the same cycle as the timeout takes priority.
        if (cpu_resettaken) begin
          state_d = ST_HOLD;
        end else if (t_elapsed >= T_TO) begin
          state_d        = ST_HARD;
          hard_reset_n_d = 1'b0;
          timeout_flag_d = 1'b1;
          p_cnt_d        = '0;
        end
      end
      ST_HARD: begin
        t_cnt_d = t_elapsed;
        if (p_cnt_q == P_LAST) begin
          state_d        = ST_HOLD;
          hard_reset_n_d = 1'b1;
        end else begin
          p_cnt_d = p_cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        t_cnt_d = t_elapsed;
        if ((t_elapsed >= T_MIN) && !trigger) begin
          state_d            = ST_IDLE;
          cpu_resetrequest_d = 1'b0;
        end
      end
      default: begin
        state_d            = ST_IDLE;
        cpu_resetrequest_d = 1'b0;
        hard_reset_n_d     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock_core_sig or negedge qsys_reset_n_sig) begin
    if (!qsys_reset_n_sig) begin
      state_q            <= ST_IDLE;
      sync_q             <= '0;
      t_cnt_q            <= '0;
      p_cnt_q            <= '0;
      cpu_resetrequest_q <= 1'b0;
      hard_reset_n_q     <= 1'b1;
      last_cause_q       <= '0;
      timeout_flag_q     <= 1'b0;
      reset_count_q      <= '0;
    end else begin
      state_q            <= state_d;
      sync_q             <= sync_d;
      t_cnt_q            <= t_cnt_d;
      p_cnt_q            <= p_cnt_d;
      cpu_resetrequest_q <= cpu_resetrequest_d;
      hard_reset_n_q     <= hard_reset_n_d;
      last_cause_q       <= last_cause_d;
      timeout_flag_q     <= timeout_flag_d;
      reset_count_q      <= reset_count_d;
    end
  end

  assign cpu_resetrequest = cpu_resetrequest_q;
  assign hard_reset_n     = hard_reset_n_q;
  assign busy             = (state_q != ST_IDLE);
  assign last_cause       = last_cause_q;
  assign timeout_flag     = timeout_flag_q;
  assign reset_count      = reset_count_q;

endmodule

// File: tb/tb_swi_reset_sequencer.sv
// tb_swi_reset_sequencer: self-checking bench for swi_reset_sequencer with default parameters.
// Each completed sequence is predicted (cause, count, high length, timeout) when it is started
// and compared against what a release monitor observed when cpu_resetrequest falls.
module tb_swi_reset_sequencer;

  logic       clock_core_sig   = 1'b0;
  logic       qsys_reset_n_sig = 1'b1;
  logic [1:0] req_in           = 2'b00;
  logic [1:0] req_mask         = 2'b00;
  logic       cpu_resettaken   = 1'b0;
  logic       clear_status     = 1'b0;
  logic       cpu_resetrequest;
  logic       hard_reset_n;
  logic       busy;
  logic [1:0] last_cause;
  logic       timeout_flag;
  logic [7:0] reset_count;
  logic [13:0] outs;

  localparam logic [13:0] RST_OUTS = {1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'd0};

  int vectors     = 0;
  int miscompares = 0;

  swi_reset_sequencer #(
    .NUM_REQ(2), .SYNC_STAGES(2), .MIN_ASSERT(16), .TAKEN_TIMEOUT(1024), .HARD_PULSE(32)
  ) dut (
    .clock_core_sig   (clock_core_sig),
    .qsys_reset_n_sig (qsys_reset_n_sig),
    .req_in           (req_in),
    .req_mask         (req_mask),
    .cpu_resettaken   (cpu_resettaken),
    .clear_status     (clear_status),
    .cpu_resetrequest (cpu_resetrequest),
    .hard_reset_n     (hard_reset_n),
    .busy             (busy),
    .last_cause       (last_cause),
    .timeout_flag     (timeout_flag),
    .reset_count      (reset_count)
  );

  assign outs = {cpu_resetrequest, hard_reset_n, busy, last_cause, timeout_flag, reset_count};

  always #5 clock_core_sig = ~clock_core_sig;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0] cause;
    logic [7:0] count;
    int         hi_len;
    logic       tflag;
  } exp_t;

  exp_t exp_q[$];
  int   model_count = 0;
  int   n_popped    = 0;

  task automatic push_exp(input logic [1:0] cause, input int hi_len, input logic tflag);
    exp_t e;
    model_count = (model_count < 255) ? model_count + 1 : 255;
    e.cause  = cause;
    e.count  = 8'(model_count);
    e.hi_len = hi_len;
    e.tflag  = tflag;
    exp_q.push_back(e);
  endtask

  // Release monitor: counts high cycles and snapshots status in the cycle the request drops.
  int         hi_run  = 0;
  int         rel_cnt = 0;
  int         obs_hi_len = 0;
  logic [1:0] obs_cause  = 2'b00;
  logic [7:0] obs_count  = 8'd0;
  logic       obs_tflag  = 1'b0;

  always @(negedge clock_core_sig) begin
    if (!qsys_reset_n_sig) begin
      hi_run = 0;
    end else if (cpu_resetrequest === 1'b1) begin
      hi_run++;
    end else if (hi_run > 0) begin
      obs_hi_len = hi_run;
      obs_cause  = last_cause;
      obs_count  = reset_count;
      obs_tflag  = timeout_flag;
      rel_cnt++;
      hi_run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock_core_sig);
    #1;
  endtask

  task automatic wait_rise(input int budget, output int at);
    at = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (cpu_resetrequest === 1'b1) begin
        at = i;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int budget, output int at);
    at = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (cpu_resetrequest === 1'b0) begin
        at = i;
        break;
      end
    end
  endtask

  task automatic wait_rel(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (rel_cnt > n_popped) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (rel_cnt > n_popped) ok = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    qsys_reset_n_sig = 1'b1;
    #2 qsys_reset_n_sig = 1'b0;
    #1;
    vectors++;
    if (outs !== RST_OUTS) begin
      miscompares++;
      $display("FAIL reset_in: got %b want %b", outs, RST_OUTS);
    end
    tick();
    tick();
    qsys_reset_n_sig = 1'b1;
    tick();
    tick();
    vectors++;
    if (outs !== RST_OUTS) begin
      miscompares++;
      $display("FAIL reset_idle: got %b want %b", outs, RST_OUTS);
    end
  endtask

  task automatic test_basic();
    int at; bit ok; exp_t e;
    req_in = 2'b01;
    push_exp(2'b01, 16, 1'b0);
    wait_rise(10, at);
    vectors++;
    if (at != 3) begin
      miscompares++;
      $display("FAIL basic_latency: rose at edge %0d want 3", at);
    end
    vectors++;
    if (outs !== {1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL basic_start: got %b want %b", outs, {1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 8'd1});
    end
    req_in = 2'b00;
    tick();
    tick();
    cpu_resettaken = 1'b1;
    tick();
    cpu_resettaken = 1'b0;
    wait_rel(40, ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL basic_seq: no release seen (seen=%0b queued=%0d)", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front(); n_popped++;
      if (obs_cause !== e.cause || obs_count !== e.count || obs_hi_len != e.hi_len || obs_tflag !== e.tflag) begin
        miscompares++;
        $display("FAIL basic_seq: got cause=%b cnt=%0d hi=%0d tf=%b want cause=%b cnt=%0d hi=%0d tf=%b",
                 obs_cause, obs_count, obs_hi_len, obs_tflag, e.cause, e.count, e.hi_len, e.tflag);
      end
    end
  endtask

  task automatic test_held();
    int at; bit ok; exp_t e;
    req_in = 2'b10;
    push_exp(2'b10, 100, 1'b0);
    wait_rise(10, at);
    cpu_resettaken = 1'b1;
    tick();
    cpu_resettaken = 1'b0;
    repeat (96) tick();
    req_in = 2'b00;
    wait_fall(10, at);
    vectors++;
    if (at != 3) begin
      miscompares++;
      $display("FAIL held_release: fell %0d edges after drop want 3", at);
    end
    vectors++;
    if (outs !== {1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'(model_count)}) begin
      miscompares++;
      $display("FAIL held_idle: got %b want %b", outs, {1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 8'(model_count)});
    end
    wait_rel(5, ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL held_seq: no release seen (seen=%0b queued=%0d)", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front(); n_popped++;
      if (obs_cause !== e.cause || obs_count !== e.count || obs_hi_len != e.hi_len || obs_tflag !== e.tflag) begin
        miscompares++;
        $display("FAIL held_seq: got cause=%b cnt=%0d hi=%0d tf=%b want cause=%b cnt=%0d hi=%0d tf=%b",
                 obs_cause, obs_count, obs_hi_len, obs_tflag, e.cause, e.count, e.hi_len, e.tflag);
      end
    end
  endtask

  task automatic test_timeout();
    int at; int fall_at; int lo; bit ok; bit busy_ok; exp_t e;
    req_in = 2'b01;
    push_exp(2'b01, 1059, 1'b1);
    wait_rise(10, at);
    busy_ok = 1'b1;
    fall_at = -1;
    for (int i = 1; i <= 1100; i++) begin
      if (i == 1024) clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hard_reset_n === 1'b0) begin
        fall_at = i;
        break;
      end
    end
    vectors++;
    if (fall_at != 1024) begin
      miscompares++;
      $display("FAIL timeout_fall: hard reset fell after %0d high cycles want 1024", fall_at);
    end
    vectors++;
    if (timeout_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_set_wins: timeout_flag=%b want 1", timeout_flag);
    end
    lo = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (hard_reset_n !== 1'b0) break;
      lo++;
    end
    vectors++;
    if (lo != 32) begin
      miscompares++;
      $display("FAIL timeout_pulse: hard reset low %0d cycles want 32", lo);
    end
    vectors++;
    if (busy_ok !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_busy: busy dropped during escalation (ok=%b want 1)", busy_ok);
    end
    req_in = 2'b00;
    wait_fall(10, at);
    wait_rel(5, ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL timeout_seq: no release seen (seen=%0b queued=%0d)", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front(); n_popped++;
      if (obs_cause !== e.cause || obs_count !== e.count || obs_hi_len != e.hi_len || obs_tflag !== e.tflag) begin
        miscompares++;
        $display("FAIL timeout_seq: got cause=%b cnt=%0d hi=%0d tf=%b want cause=%b cnt=%0d hi=%0d tf=%b",
                 obs_cause, obs_count, obs_hi_len, obs_tflag, e.cause, e.count, e.hi_len, e.tflag);
      end
    end
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    vectors++;
    if (timeout_flag !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: timeout_flag=%b want 0", timeout_flag);
    end
  endtask

  task automatic test_mask();
    int at; bit ok; bit idle_ok; exp_t e;
    req_mask = 2'b01;
    req_in   = 2'b01;
    idle_ok  = 1'b1;
    repeat (10) begin
      tick();
      if (busy !== 1'b0 || cpu_resetrequest !== 1'b0) idle_ok = 1'b0;
    end
    vectors++;
    if (!idle_ok || outs !== {1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'(model_count)}) begin
      miscompares++;
      $display("FAIL mask_ignore: got %b idle=%b want %b", outs, idle_ok,
               {1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'(model_count)});
    end
    req_in = 2'b11;
    push_exp(2'b10, 43, 1'b0);
    wait_rise(10, at);
    vectors++;
    if (at != 3 || last_cause !== 2'b10) begin
      miscompares++;
      $display("FAIL mask_start: rose at %0d cause=%b want 3 and 10", at, last_cause);
    end
    cpu_resettaken = 1'b1;
    tick();
    cpu_resettaken = 1'b0;
    req_in = 2'b01;
    repeat (4) tick();
    req_mask = 2'b00;
    repeat (35) tick();
    vectors++;
    if (cpu_resetrequest !== 1'b1) begin
      miscompares++;
      $display("FAIL mask_hold: cpu_resetrequest=%b want 1 while req_in[0] held", cpu_resetrequest);
    end
    req_in = 2'b00;
    wait_fall(10, at);
    wait_rel(5, ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL mask_seq: no release seen (seen=%0b queued=%0d)", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front(); n_popped++;
      if (obs_cause !== e.cause || obs_count !== e.count || obs_hi_len != e.hi_len || obs_tflag !== e.tflag) begin
        miscompares++;
        $display("FAIL mask_seq: got cause=%b cnt=%0d hi=%0d tf=%b want cause=%b cnt=%0d hi=%0d tf=%b",
                 obs_cause, obs_count, obs_hi_len, obs_tflag, e.cause, e.count, e.hi_len, e.tflag);
      end
    end
  endtask

  task automatic test_taken_at_timeout();
    int at; bit ok; bit hard_ok; exp_t e;
    req_in = 2'b01;
    push_exp(2'b01, 1027, 1'b0);
    wait_rise(10, at);
    repeat (1023) tick();
    cpu_resettaken = 1'b1;
    tick();
    cpu_resettaken = 1'b0;
    vectors++;
    if (hard_reset_n !== 1'b1 || timeout_flag !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL race_edge: hard=%b tf=%b busy=%b want 1 0 1", hard_reset_n, timeout_flag, busy);
    end
    req_in = 2'b00;
    hard_ok = 1'b1;
    at = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (hard_reset_n !== 1'b1) hard_ok = 1'b0;
      if (cpu_resetrequest === 1'b0) begin
        at = i;
        break;
      end
    end
    vectors++;
    if (!hard_ok || at != 3) begin
      miscompares++;
      $display("FAIL race_hold: hard_ok=%b fell %0d edges after drop want 1 and 3", hard_ok, at);
    end
    wait_rel(5, ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL race_seq: no release seen (seen=%0b queued=%0d)", ok, exp_q.size());
    end else begin
      e = exp_q.pop_front(); n_popped++;
      if (obs_cause !== e.cause || obs_count !== e.count || obs_hi_len != e.hi_len || obs_tflag !== e.tflag) begin
        miscompares++;
        $display("FAIL race_seq: got cause=%b cnt=%0d hi=%0d tf=%b want cause=%b cnt=%0d hi=%0d tf=%b",
                 obs_cause, obs_count, obs_hi_len, obs_tflag, e.cause, e.count, e.hi_len, e.tflag);
      end
    end
  endtask

  task automatic test_back_to_back();
    int at; bit ok; exp_t e;
    req_in = 2'b01;
    cpu_resettaken = 1'b1;
    wait_rise(10, at);
    for (int k = 0; k < 260; k++) begin
      push_exp(2'b01, 16, 1'b0);
      repeat (13) tick();
      req_in = 2'b00;
      tick();
      if (k < 259) req_in = 2'b01;
      tick();
      tick();
      vectors++;
      if (cpu_resetrequest !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_release: seq %0d cpu_resetrequest=%b want 0", k, cpu_resetrequest);
      end
      tick();
      if (k < 259) begin
        vectors++;
        if (cpu_resetrequest !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_restart: seq %0d cpu_resetrequest=%b want 1", k, cpu_resetrequest);
        end
      end
      wait_rel(4, ok);
      vectors++;
      if (!ok || exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_seq: seq %0d no release seen (seen=%0b queued=%0d)", k, ok, exp_q.size());
      end else begin
        e = exp_q.pop_front(); n_popped++;
        if (obs_cause !== e.cause || obs_count !== e.count || obs_hi_len != e.hi_len || obs_tflag !== e.tflag) begin
          miscompares++;
          $display("FAIL b2b_seq: seq %0d got cause=%b cnt=%0d hi=%0d tf=%b want cause=%b cnt=%0d hi=%0d tf=%b",
                   k, obs_cause, obs_count, obs_hi_len, obs_tflag, e.cause, e.count, e.hi_len, e.tflag);
        end
      end
    end
    cpu_resettaken = 1'b0;
    vectors++;
    if (outs !== {1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'd255}) begin
      miscompares++;
      $display("FAIL b2b_saturate: got %b want %b", outs, {1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 8'd255});
    end
  endtask

  task automatic test_async_reset();
    int at; int fall_at;
    // Abort while waiting for the acknowledge.
    req_in = 2'b01;
    wait_rise(10, at);
    tick();
    tick();
    #2 qsys_reset_n_sig = 1'b0;
    #1;
    vectors++;
    if (outs !== RST_OUTS) begin
      miscompares++;
      $display("FAIL areset_req: got %b want %b", outs, RST_OUTS);
    end
    req_in = 2'b00;
    tick();
    tick();
    qsys_reset_n_sig = 1'b1;
    model_count = 0;
    tick();
    // Abort in the middle of the hard reset pulse.
    req_in = 2'b01;
    wait_rise(10, at);
    fall_at = -1;
    for (int i = 1; i <= 1100; i++) begin
      tick();
      if (hard_reset_n === 1'b0) begin
        fall_at = i;
        break;
      end
    end
    vectors++;
    if (fall_at != 1024) begin
      miscompares++;
      $display("FAIL areset_reach_hard: hard reset fell after %0d cycles want 1024", fall_at);
    end
    repeat (3) tick();
    #2 qsys_reset_n_sig = 1'b0;
    #1;
    vectors++;
    if (outs !== RST_OUTS) begin
      miscompares++;
      $display("FAIL areset_hard: got %b want %b", outs, RST_OUTS);
    end
    req_in = 2'b00;
    tick();
    tick();
    qsys_reset_n_sig = 1'b1;
    tick();
    tick();
    vectors++;
    if (outs !== RST_OUTS || exp_q.size() != 0 || rel_cnt != n_popped) begin
      miscompares++;
      $display("FAIL areset_after: got %b queued=%0d releases=%0d popped=%0d want %b 0 and equal",
               outs, exp_q.size(), rel_cnt, n_popped, RST_OUTS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_held();
    test_timeout();
    test_mask();
    test_taken_at_timeout();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit (vectors=%0d)", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule
